rd_req_arbiter: RTL

- Shares one AXI read master's user-side command port between two independent read requesters (for example, a display fetch and a host read path).
- Latches pulse-style read requests and picks one requester round-robin.
- Issues the chosen request as a single-cycle trigger with address and length held stable for the whole transaction.
- Steers returned read data and the completion pulse back to the requester that owns the transaction.

---
 rtl/rd_req_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rd_req_arbiter.sv
// Two-requester front end for a single AXI read master command port.
// Pulse requests are latched per requester, granted round-robin, issued as a
// one-cycle trigger, and the returned data/done are steered to the owner.
module rd_req_arbiter #(
   parameter int unsigned ADDR_WIDTH = 27,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  init_end,
   input  logic                  req0_trig,
   input  logic [7:0]            req0_len,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   output logic                  req0_busy,
   output logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_data_en,
   output logic                  req0_done,
   input  logic                  req1_trig,
   input  logic [7:0]            req1_len,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   output logic                  req1_busy,
   output logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_data_en,
   output logic                  req1_done,
   output logic                  rd_trig,
   output logic [7:0]            rd_len,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_ready,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_data_en,
   input  logic                  rd_done
);

   typedef enum logic [1:0] {StIdle, StIssue, StBusy, StZdone} state_e;

   state_e                state_q;
   logic                  owner_q;
   logic                  ptr_q;
   logic                  pend0_q;
   logic                  pend1_q;
   logic [ADDR_WIDTH-1:0] slot0_addr_q;
   logic [ADDR_WIDTH-1:0] slot1_addr_q;
   logic [7:0]            slot0_len_q;
   logic [7:0]            slot1_len_q;
   logic                  rd_trig_q;
   logic [7:0]            rd_len_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic                  done0_q;
   logic                  done1_q;

   logic                  active;
   logic                  busy0;
   logic                  busy1;
   logic                  arb_go;
   logic                  winner;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [7:0]            win_len;

   // Busy flags, arbitration qualifier and winner selection.
   always_comb begin
      active   = (state_q != StIdle);
      busy0    = pend0_q | (active & ~owner_q);
      busy1    = pend1_q | (active & owner_q);
      arb_go   = (state_q == StIdle) & init_end & rd_ready & (pend0_q | pend1_q);
      // Pointer only matters when both are pending; otherwise the lone pender wins.
      winner   = (pend0_q & pend1_q) ? ptr_q : pend1_q;
      win_addr = winner ? slot1_addr_q : slot0_addr_q;
      win_len  = winner ? slot1_len_q : slot0_len_q;
   end

   // Request capture, arbitration FSM and registered command/done outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         ptr_q        <= 1'b0;
         pend0_q      <= 1'b0;
         pend1_q      <= 1'b0;
         slot0_addr_q <= '0;
         slot1_addr_q <= '0;
         slot0_len_q  <= '0;
         slot1_len_q  <= '0;
         rd_trig_q    <= 1'b0;
         rd_len_q     <= '0;
         rd_addr_q    <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
      end else begin
         rd_trig_q <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;

         if (req0_trig && !busy0) begin
            pend0_q      <= 1'b1;
            slot0_addr_q <= req0_addr;
            slot0_len_q  <= req0_len;
         end
         if (req1_trig && !busy1) begin
            pend1_q      <= 1'b1;
            slot1_addr_q <= req1_addr;
            slot1_len_q  <= req1_len;
         end

         unique case (state_q)
            StIdle: begin
               if (arb_go) begin
                  owner_q <= winner;
                  if (winner) pend1_q <= 1'b0;
                  else        pend0_q <= 1'b0;
                  if (win_len == 8'd0) begin
                     // Empty transfer: complete locally, never bother the master.
                     state_q <= StZdone;
                  end else begin
                     state_q   <= StIssue;
                     rd_trig_q <= 1'b1;
                     rd_addr_q <= win_addr;
                     rd_len_q  <= win_len;
                  end
               end
            end
            StIssue: begin
               state_q <= StBusy;
            end
            StBusy: begin
               if (rd_done) begin
                  done0_q <= ~owner_q;
                  done1_q <= owner_q;
                  ptr_q   <= ~owner_q;
                  state_q <= StIdle;
               end
            end
            StZdone: begin
               done0_q <= ~owner_q;
               done1_q <= owner_q;
               ptr_q   <= ~owner_q;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Data is broadcast; only the owner's valid is raised, and only while busy.
   always_comb begin
      req0_busy    = busy0;
      req1_busy    = busy1;
      req0_data    = rd_data;
      req1_data    = rd_data;
      req0_data_en = (state_q == StBusy) & ~owner_q & rd_data_en;
      req1_data_en = (state_q == StBusy) & owner_q & rd_data_en;
      req0_done    = done0_q;
      req1_done    = done1_q;
      rd_trig      = rd_trig_q;
      rd_len       = rd_len_q;
      rd_addr      = rd_addr_q;
   end

endmodule
